// File: rtl/card_display_pkg.sv
// Shared card-slot constants and geometry helpers for the scheduler and renderer.
package card_display_pkg;

  localparam int NUM_W      = 12;
  localparam int NUM_SLOTS  = 4;
  localparam int WORD_W     = NUM_W * NUM_SLOTS;
  localparam int SLOT_IDX_W = 2;
  localparam int COORD_W    = 10;

  localparam int DEF_X0           = 220;
  localparam int DEF_Y0           = 140;
  localparam int DEF_CARD_W       = 48;
  localparam int DEF_CARD_H       = 64;
  localparam int DEF_GAP          = 16;
  localparam int DEF_BLINK_FRAMES = 30;

  typedef struct packed {
    logic                  hit;
    logic [SLOT_IDX_W-1:0] idx;
    logic [COORD_W-1:0]    org_x;
  } slot_hit_t;

  function automatic logic [COORD_W-1:0] slot_origin_x(input int x0, input int card_w,
                                                       input int gap, input int i);
    return COORD_W'(x0 + i * (card_w + gap));
  endfunction

endpackage

// File: rtl/card_slot_decode.sv
// Combinational beam-position to card-slot decode; zero latency, no handshake.
module card_slot_decode
  import card_display_pkg::*;
#(
  parameter int X0     = DEF_X0,
  parameter int Y0     = DEF_Y0,
  parameter int CARD_W = DEF_CARD_W,
  parameter int CARD_H = DEF_CARD_H,
  parameter int GAP    = DEF_GAP
) (
  input  logic [COORD_W-1:0] sx,
  input  logic [COORD_W-1:0] sy,
  output slot_hit_t          slot
);

  logic                 y_in;
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [COORD_W-1:0]   lo_x [NUM_SLOTS];
  logic [COORD_W-1:0]   hi_x [NUM_SLOTS];

  assign y_in = (sy >= COORD_W'(Y0)) && (sy < COORD_W'(Y0 + CARD_H));

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign lo_x[i]    = slot_origin_x(X0, CARD_W, GAP, i);
    assign hi_x[i]    = slot_origin_x(X0, CARD_W, GAP, i) + COORD_W'(CARD_W);
    assign hit_vec[i] = y_in && (sx >= lo_x[i]) && (sx < hi_x[i]);
  end

  // Slots never overlap, so a priority scan yields the single hit.
  always_comb begin
    slot.hit   = 1'b0;
    slot.idx   = '0;
    slot.org_x = COORD_W'(X0);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hit_vec[i]) begin
        slot.hit   = 1'b1;
        slot.idx   = SLOT_IDX_W'(i);
        slot.org_x = lo_x[i];
      end
    end
  end

endmodule

// File: rtl/card_display_scheduler.sv
// Slot sequencing (1 clk after pix_en) and frame-synchronous number-word commit; upd_ready low while a word is pending.
// CARD_DISPLAY_SCHED_BLINK_EN enables the frame-counted highlight blink.
module card_display_scheduler
  import card_display_pkg::*;
#(
  parameter int X0           = DEF_X0,
  parameter int Y0           = DEF_Y0,
  parameter int CARD_W       = DEF_CARD_W,
  parameter int CARD_H       = DEF_CARD_H,
  parameter int GAP          = DEF_GAP,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  input  logic [COORD_W-1:0]    sx,
  input  logic [COORD_W-1:0]    sy,
  input  logic                  frame_start,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [WORD_W-1:0]     upd_numbers,
  input  logic [NUM_SLOTS-1:0]  sel,
  output logic [WORD_W-1:0]     numbers_concat,
  output logic [COORD_W-1:0]    sx_offset,
  output logic [COORD_W-1:0]    sy_offset,
  output logic [SLOT_IDX_W-1:0] slot_idx,
  output logic                  slot_active,
  output logic                  highlight
);

  localparam logic [0:0] ST_EMPTY   = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  slot_hit_t slot;

  logic [0:0]            state_q, state_d;
  logic [WORD_W-1:0]     pending_q, pending_d;
  logic [WORD_W-1:0]     numbers_q, numbers_d;
  logic [COORD_W-1:0]    sx_off_q, sx_off_d;
  logic [COORD_W-1:0]    sy_off_q, sy_off_d;
  logic [SLOT_IDX_W-1:0] idx_q, idx_d;
  logic                  active_q, active_d;
  logic                  sel_hit_q, sel_hit_d;

  card_slot_decode #(
    .X0     (X0),
    .Y0     (Y0),
    .CARD_W (CARD_W),
    .CARD_H (CARD_H),
    .GAP    (GAP)
  ) u_decode (
    .sx   (sx),
    .sy   (sy),
    .slot (slot)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    numbers_d = numbers_q;
    case (state_q)
      ST_EMPTY: begin
        // A word arriving with frame_start waits for the next frame.
        if (upd_valid) begin
          pending_d = upd_numbers;
          state_d   = ST_PENDING;
        end
      end
      default: begin
        if (frame_start) begin
          numbers_d = pending_q;
          state_d   = ST_EMPTY;
        end
      end
    endcase
  end

  always_comb begin
    sx_off_d  = sx_off_q;
    sy_off_d  = sy_off_q;
    idx_d     = idx_q;
    active_d  = active_q;
    sel_hit_d = sel_hit_q;
    if (pix_en) begin
      active_d  = slot.hit;
      sel_hit_d = slot.hit & sel[slot.idx];
      if (slot.hit) begin
        sx_off_d = slot.org_x;
        sy_off_d = COORD_W'(Y0);
        idx_d    = slot.idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      pending_q <= '0;
      numbers_q <= '0;
      sx_off_q  <= COORD_W'(X0);
      sy_off_q  <= COORD_W'(Y0);
      idx_q     <= '0;
      active_q  <= 1'b0;
      sel_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      numbers_q <= numbers_d;
      sx_off_q  <= sx_off_d;
      sy_off_q  <= sy_off_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      sel_hit_q <= sel_hit_d;
    end
  end

`ifdef CARD_DISPLAY_SCHED_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_q, blink_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_start) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign highlight = active_q & sel_hit_q & blink_q;
`else
  assign highlight = active_q & sel_hit_q;
`endif

  assign upd_ready      = (state_q == ST_EMPTY);
  assign numbers_concat = numbers_q;
  assign sx_offset      = sx_off_q;
  assign sy_offset      = sy_off_q;
  assign slot_idx       = idx_q;
  assign slot_active    = active_q;

endmodule

// File: tb/tb_card_display_scheduler.sv
// Directed bench for card_display_scheduler: reset, update handshake, slot decode and highlight.
module tb_card_display_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic        frame_start;
  logic        upd_valid;
  logic        upd_ready;
  logic [47:0] upd_numbers;
  logic [3:0]  sel;
  logic [47:0] numbers_concat;
  logic [9:0]  sx_offset;
  logic [9:0]  sy_offset;
  logic [1:0]  slot_idx;
  logic        slot_active;
  logic        highlight;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  card_display_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pix_en         (pix_en),
    .sx             (sx),
    .sy             (sy),
    .frame_start    (frame_start),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_numbers    (upd_numbers),
    .sel            (sel),
    .numbers_concat (numbers_concat),
    .sx_offset      (sx_offset),
    .sy_offset      (sy_offset),
    .slot_idx       (slot_idx),
    .slot_active    (slot_active),
    .highlight      (highlight)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pixel(input logic [9:0] x, input logic [9:0] y);
    pix_en = 1'b1;
    sx     = x;
    sy     = y;
    tick();
    pix_en = 1'b0;
  endtask

  logic exp_hl;

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; sx = '0; sy = '0; frame_start = 1'b0;
    upd_valid = 1'b0; upd_numbers = '0; sel = '0;
    repeat (3) tick();

    chk("rst_numbers", numbers_concat, 48'h0);
    chk("rst_sx_offset", sx_offset, 10'd220);
    chk("rst_sy_offset", sy_offset, 10'd140);
    chk("rst_slot_idx", slot_idx, 2'd0);
    chk("rst_slot_active", slot_active, 1'b0);
    chk("rst_highlight", highlight, 1'b0);
    chk("rst_upd_ready", upd_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Plain update: captured, held until frame_start.
    upd_valid = 1'b1; upd_numbers = 48'h001_002_003_004;
    tick();
    upd_valid = 1'b0;
    chk("upd_ready_drop", upd_ready, 1'b0);
    chk("no_commit_yet", numbers_concat, 48'h0);
    tick(); tick();
    chk("still_no_commit", numbers_concat, 48'h0);
    frame_pulse();
    chk("commit_word1", numbers_concat, 48'h001_002_003_004);
    chk("ready_after_commit", upd_ready, 1'b1);

    // Offer coincides with frame_start: commit deferred one frame.
    upd_valid = 1'b1; upd_numbers = 48'haaa_bbb_ccc_ddd; frame_start = 1'b1;
    tick();
    upd_valid = 1'b0; frame_start = 1'b0;
    chk("coincident_not_committed", numbers_concat, 48'h001_002_003_004);
    chk("coincident_captured", upd_ready, 1'b0);
    tick();
    frame_pulse();
    chk("coincident_commit_next", numbers_concat, 48'haaa_bbb_ccc_ddd);

    // Offer during PENDING is refused.
    upd_valid = 1'b1; upd_numbers = 48'h111_222_333_444;
    tick();
    upd_numbers = 48'h555_666_777_888;
    tick();
    chk("pending_refuses", upd_ready, 1'b0);
    upd_valid = 1'b0;
    frame_pulse();
    chk("pending_keeps_first", numbers_concat, 48'h111_222_333_444);

    // Slot decode.
    sel = 4'b0010;
    pixel(10'd284, 10'd140);
    chk("s1_idx", slot_idx, 2'd1);
    chk("s1_sx_offset", sx_offset, 10'd284);
    chk("s1_sy_offset", sy_offset, 10'd140);
    chk("s1_active", slot_active, 1'b1);
    chk("s1_highlight", highlight, 1'b1);
    sx = 10'd0;
    tick();
    chk("hold_no_pix_en", slot_active, 1'b1);
    pixel(10'd268, 10'd150);
    chk("gap_inactive", slot_active, 1'b0);
    chk("gap_hold_sx", sx_offset, 10'd284);
    chk("gap_hold_idx", slot_idx, 2'd1);
    chk("gap_highlight", highlight, 1'b0);
    pixel(10'd459, 10'd203);
    chk("s3_last_active", slot_active, 1'b1);
    chk("s3_idx", slot_idx, 2'd3);
    chk("s3_sx_offset", sx_offset, 10'd412);
    chk("s3_not_selected", highlight, 1'b0);
    pixel(10'd460, 10'd150);
    chk("s3_past_right", slot_active, 1'b0);
    pixel(10'd220, 10'd140);
    chk("s0_first_idx", slot_idx, 2'd0);
    chk("s0_first_sx", sx_offset, 10'd220);
    pixel(10'd219, 10'd150);
    chk("left_of_s0", slot_active, 1'b0);
    pixel(10'd230, 10'd204);
    chk("below_slots", slot_active, 1'b0);
    pixel(10'd230, 10'd139);
    chk("above_slots", slot_active, 1'b0);

    // Reset while PENDING discards the word.
    upd_valid = 1'b1; upd_numbers = 48'h999_888_777_666;
    tick();
    upd_valid = 1'b0;
    chk("pending_before_reset", upd_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("reset_clears_numbers", numbers_concat, 48'h0);
    chk("reset_ready", upd_ready, 1'b1);
    frame_pulse();
    chk("reset_nothing_commits", numbers_concat, 48'h0);

    // Highlight across frames; the reset above restarted the blink phase,
    // and one frame_start has already been counted.
    sel = 4'b0010; pix_en = 1'b1; sx = 10'd290; sy = 10'd160;
    tick();
    chk("blink_f1", highlight, 1'b1);
    for (int f = 2; f <= 60; f++) begin
      frame_pulse();
`ifdef CARD_DISPLAY_SCHED_BLINK_EN
      exp_hl = (f < 30 || f >= 60) ? 1'b1 : 1'b0;
`else
      exp_hl = 1'b1;
`endif
      if (f == 29 || f == 30 || f == 45 || f == 59 || f == 60)
        chk($sformatf("blink_f%0d", f), highlight, exp_hl);
    end
    pix_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
